// File: rtl/alien_sprite_reader_if.sv
// ---------------------------------------------------------------------------
// alien_sprite_reader_if : scan, game-control, RAM-read and pixel-out signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alien_sprite_reader_if;
  logic        frame_start;
  logic [9:0]  alien_x;
  logic [9:0]  alien_y;
  logic        spawn;
  logic        kill;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [18:0] read_address;
  logic [23:0] data_Out;
  logic [23:0] pixel_out;
  logic        pixel_hit;
  logic        alive_o;

  modport master (
    output frame_start, alien_x, alien_y, spawn, kill, DrawX, DrawY, data_Out,
    input  read_address, pixel_out, pixel_hit, alive_o
  );

  modport slave (
    input  frame_start, alien_x, alien_y, spawn, kill, DrawX, DrawY, data_Out,
    output read_address, pixel_out, pixel_hit, alive_o
  );
endinterface

`default_nettype wire

// File: rtl/alien_sprite_reader.sv
// ---------------------------------------------------------------------------
// alien_sprite_reader : box test, sprite RAM addressing and 3-stage pixel path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alien_sprite_reader #(
  parameter int          SPR_W       = 40,
  parameter logic [23:0] TRANSPARENT = 24'hFF00FF,
  parameter int          FLIP_FRAMES = 16,
  parameter int          DIE_FRAMES  = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  alien_sprite_reader_if.slave bus
);

  localparam int OW = $clog2(SPR_W);
  localparam int AW = $clog2(SPR_W * SPR_W);
  localparam int FW = $clog2(FLIP_FRAMES);
  localparam int DW = $clog2(DIE_FRAMES);

  localparam logic [1:0] ST_DEAD  = 2'd0;
  localparam logic [1:0] ST_ALIVE = 2'd1;
  localparam logic [1:0] ST_DYING = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [FW-1:0] flip_cnt_q;
  logic          flip_q;
  logic [DW-1:0] die_cnt_q;
  logic [9:0]    x_lat_q, y_lat_q;
  logic          w_alive, w_visible;

  // ---------------- state machine ----------------
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_DEAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DEAD:  if (bus.spawn) state_d = ST_ALIVE;
      ST_ALIVE: if (bus.kill)  state_d = ST_DYING;
      ST_DYING: if (bus.frame_start && die_cnt_q == DW'(DIE_FRAMES - 1)) state_d = ST_DEAD;
      default:  state_d = ST_DEAD;
    endcase
  end

  always_comb begin
    w_alive   = (state_q == ST_ALIVE);
    w_visible = w_alive || ((state_q == ST_DYING) && !die_cnt_q[2]);
  end

  // Counter is held at zero outside DYING, so entry into DYING starts from 0
  // and a frame_start on the entry edge is never counted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      flip_cnt_q <= '0;
      flip_q     <= 1'b0;
      die_cnt_q  <= '0;
      x_lat_q    <= '0;
      y_lat_q    <= '0;
    end else begin
      if (bus.frame_start) begin
        x_lat_q <= bus.alien_x;
        y_lat_q <= bus.alien_y;
      end
      if (bus.frame_start && state_q == ST_ALIVE) begin
        if (flip_cnt_q == FW'(FLIP_FRAMES - 1)) begin
          flip_cnt_q <= '0;
          flip_q     <= ~flip_q;
        end else begin
          flip_cnt_q <= flip_cnt_q + 1'b1;
        end
      end
      if (state_q != ST_DYING)  die_cnt_q <= '0;
      else if (bus.frame_start) die_cnt_q <= die_cnt_q + 1'b1;
    end
  end

  // ---------------- stage 1: box test and address ----------------
  logic [10:0]   w_x_end, w_y_end;
  logic          w_inbox;
  logic [OW-1:0] w_dx, w_dy, w_col;
  logic [AW-1:0] w_addr;
  logic [18:0]   read_address_d, read_address_q;

  always_comb begin
    w_x_end = {1'b0, x_lat_q} + 11'(SPR_W);
    w_y_end = {1'b0, y_lat_q} + 11'(SPR_W);
    w_inbox = ({1'b0, bus.DrawX} >= {1'b0, x_lat_q}) && ({1'b0, bus.DrawX} < w_x_end) &&
              ({1'b0, bus.DrawY} >= {1'b0, y_lat_q}) && ({1'b0, bus.DrawY} < w_y_end);
    w_dx    = OW'(bus.DrawX - x_lat_q);
    w_dy    = OW'(bus.DrawY - y_lat_q);
    w_col   = flip_q ? (OW'(SPR_W - 1) - w_dx) : w_dx;
    w_addr  = AW'(w_dy) * AW'(SPR_W) + AW'(w_col);
    read_address_d = w_inbox ? 19'(w_addr) : '0;
  end

  // ---------------- pipeline ----------------
  logic        s1_q, v1_q, s2_q, v2_q;
  logic        pixel_hit_q;
  logic [23:0] pixel_out_q;
  logic        w_hit;

  assign w_hit = s2_q && v2_q && (bus.data_Out != TRANSPARENT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address_q <= '0;
      s1_q           <= 1'b0;
      v1_q           <= 1'b0;
      s2_q           <= 1'b0;
      v2_q           <= 1'b0;
      pixel_hit_q    <= 1'b0;
      pixel_out_q    <= '0;
    end else begin
      read_address_q <= read_address_d;
      s1_q           <= w_inbox;
      v1_q           <= w_visible;
      s2_q           <= s1_q;
      v2_q           <= v1_q;
      pixel_hit_q    <= w_hit;
      pixel_out_q    <= w_hit ? bus.data_Out : '0;
    end
  end

  assign bus.read_address = read_address_q;
  assign bus.pixel_out    = pixel_out_q;
  assign bus.pixel_hit    = pixel_hit_q;
  assign bus.alive_o      = w_alive;

endmodule

`default_nettype wire

// File: tb/tb_alien_sprite_reader.sv
// ---------------------------------------------------------------------------
// tb_alien_sprite_reader : randomized and directed bench with reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alien_sprite_reader;

  localparam logic [23:0] TRANSP = 24'hFF00FF;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  alien_sprite_reader_if bus ();

  alien_sprite_reader dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [23:0] ram [0:1599];
  always @(posedge Clk) bus.data_Out <= ram[bus.read_address[10:0]];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: 0 dead, 1 alive, 2 dying
  int m_state, m_die, m_fcnt, m_flip, m_x, m_y;

  function automatic void model_pix(input int x, input int y, output int addr,
                                    output bit hit, output logic [23:0] col);
    bit inbox, vis;
    int dx, dy;
    inbox = (x >= m_x) && (x < m_x + 40) && (y >= m_y) && (y < m_y + 40);
    vis   = (m_state == 1) || (m_state == 2 && ((m_die / 4) % 2) == 0);
    dx    = x - m_x;
    dy    = y - m_y;
    addr  = inbox ? dy * 40 + (m_flip != 0 ? 39 - dx : dx) : 0;
    hit   = inbox && vis && (ram[addr] !== TRANSP);
    col   = hit ? ram[addr] : 24'h0;
  endfunction

  task automatic model_reset;
    m_state = 0; m_die = 0; m_fcnt = 0; m_flip = 0; m_x = 0; m_y = 0;
  endtask

  task automatic frame_pulse;
    bus.frame_start = 1'b1;
    @(negedge Clk);
    bus.frame_start = 1'b0;
    m_x = int'(bus.alien_x);
    m_y = int'(bus.alien_y);
    if (m_state == 1) begin
      m_fcnt++;
      if (m_fcnt == 16) begin m_fcnt = 0; m_flip ^= 1; end
    end else if (m_state == 2) begin
      m_die++;
      if (m_die == 32) m_state = 0;
    end
  endtask

  task automatic pulse_ctrl(input bit s, input bit k);
    bus.spawn = s;
    bus.kill  = k;
    @(negedge Clk);
    bus.spawn = 1'b0;
    bus.kill  = 1'b0;
    if (m_state == 0 && s)      m_state = 1;
    else if (m_state == 1 && k) begin m_state = 2; m_die = 0; end
  endtask

  task automatic hold_pixel(input int x, input int y);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge Clk);
    n_checks += 4;
    if (bus.read_address !== 19'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", bus.read_address); end
    if (bus.pixel_out !== 24'h0)    begin n_err++; $display("FAIL reset_pix: got %h want 0", bus.pixel_out); end
    if (bus.pixel_hit !== 1'b0)     begin n_err++; $display("FAIL reset_hit: got %b want 0", bus.pixel_hit); end
    if (bus.alive_o !== 1'b0)       begin n_err++; $display("FAIL reset_alive: got %b want 0", bus.alive_o); end
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_spawn_hit;
    int px[5] = '{100, 139, 140, 139, 99};
    int py[5] = '{50, 89, 89, 49, 60};
    int ea; bit eh; logic [23:0] eo;
    bus.alien_x = 10'd100;
    bus.alien_y = 10'd50;
    pulse_ctrl(1'b1, 1'b0);
    frame_pulse();
    for (int i = 0; i < 5; i++) begin
      hold_pixel(px[i], py[i]);
      model_pix(px[i], py[i], ea, eh, eo);
      n_checks += 3;
      if (bus.read_address !== 19'(ea)) begin n_err++; $display("FAIL spawn_addr(%0d,%0d): got %0d want %0d", px[i], py[i], bus.read_address, ea); end
      if (bus.pixel_hit !== eh)        begin n_err++; $display("FAIL spawn_hit(%0d,%0d): got %b want %b", px[i], py[i], bus.pixel_hit, eh); end
      if (bus.pixel_out !== eo)        begin n_err++; $display("FAIL spawn_pix(%0d,%0d): got %h want %h", px[i], py[i], bus.pixel_out, eo); end
    end
  endtask

  task automatic test_transparent_latch;
    int px[3] = '{101, 100, 200};
    int py[3] = '{51, 50, 50};
    int ea; bit eh; logic [23:0] eo;
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 1) bus.alien_x = 10'd200;
      if (pass == 2) frame_pulse();
      for (int i = 0; i < 3; i++) begin
        hold_pixel(px[i], py[i]);
        model_pix(px[i], py[i], ea, eh, eo);
        n_checks += 3;
        if (bus.read_address !== 19'(ea)) begin n_err++; $display("FAIL latch_addr p%0d(%0d,%0d): got %0d want %0d", pass, px[i], py[i], bus.read_address, ea); end
        if (bus.pixel_hit !== eh)        begin n_err++; $display("FAIL latch_hit p%0d(%0d,%0d): got %b want %b", pass, px[i], py[i], bus.pixel_hit, eh); end
        if (bus.pixel_out !== eo)        begin n_err++; $display("FAIL latch_pix p%0d(%0d,%0d): got %h want %h", pass, px[i], py[i], bus.pixel_out, eo); end
      end
    end
    bus.alien_x = 10'd100;
    frame_pulse();
  endtask

  task automatic test_flip;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    pulse_ctrl(1'b1, 1'b0);
    repeat (15) frame_pulse();
    hold_pixel(100, 50);
    n_checks++;
    if (bus.read_address !== 19'd0) begin n_err++; $display("FAIL flip_15: got %0d want 0", bus.read_address); end
    frame_pulse();
    hold_pixel(100, 50);
    n_checks += 2;
    if (bus.read_address !== 19'd39) begin n_err++; $display("FAIL flip_16: got %0d want 39", bus.read_address); end
    if (bus.pixel_out !== ram[39])   begin n_err++; $display("FAIL flip_pix: got %h want %h", bus.pixel_out, ram[39]); end
    hold_pixel(139, 89);
    n_checks++;
    if (bus.read_address !== 19'd1560) begin n_err++; $display("FAIL flip_corner: got %0d want 1560", bus.read_address); end
  endtask

  task automatic test_random_scan;
    int ea[0:99]; bit eh[0:99]; logic [23:0] eo[0:99];
    int x, y;
    for (int r = 0; r < 6; r++) begin
      bus.alien_x = 10'($urandom_range(0, 639));
      bus.alien_y = 10'($urandom_range(0, 479));
      frame_pulse();
      for (int i = 0; i < 103; i++) begin
        if (i >= 1 && i <= 100) begin
          n_checks++;
          if (bus.read_address !== 19'(ea[i-1])) begin n_err++; $display("FAIL rand_addr r%0d i%0d: got %0d want %0d", r, i-1, bus.read_address, ea[i-1]); end
        end
        if (i >= 3) begin
          n_checks += 2;
          if (bus.pixel_hit !== eh[i-3]) begin n_err++; $display("FAIL rand_hit r%0d i%0d: got %b want %b", r, i-3, bus.pixel_hit, eh[i-3]); end
          if (bus.pixel_out !== eo[i-3]) begin n_err++; $display("FAIL rand_pix r%0d i%0d: got %h want %h", r, i-3, bus.pixel_out, eo[i-3]); end
        end
        if (i < 100) begin
          x = $urandom_range((m_x > 4) ? m_x - 4 : 0, m_x + 44);
          y = $urandom_range((m_y > 4) ? m_y - 4 : 0, m_y + 44);
          bus.DrawX = 10'(x);
          bus.DrawY = 10'(y);
          model_pix(x, y, ea[i], eh[i], eo[i]);
        end
        @(negedge Clk);
      end
    end
  endtask

  task automatic test_dying;
    int ea; bit eh; logic [23:0] eo;
    bus.alien_x = 10'd100;
    bus.alien_y = 10'd50;
    frame_pulse();
    n_checks++;
    if (bus.alive_o !== 1'b1) begin n_err++; $display("FAIL die_pre_alive: got %b want 1", bus.alive_o); end
    pulse_ctrl(1'b1, 1'b1);
    n_checks++;
    if (bus.alive_o !== 1'b0) begin n_err++; $display("FAIL die_kill_alive: got %b want 0", bus.alive_o); end
    for (int f = 1; f <= 32; f++) begin
      frame_pulse();
      hold_pixel(110, 60);
      model_pix(110, 60, ea, eh, eo);
      n_checks += 2;
      if (bus.pixel_hit !== eh) begin n_err++; $display("FAIL die_hit f%0d: got %b want %b", f, bus.pixel_hit, eh); end
      if (bus.pixel_out !== eo) begin n_err++; $display("FAIL die_pix f%0d: got %h want %h", f, bus.pixel_out, eo); end
    end
    pulse_ctrl(1'b0, 1'b1);
    hold_pixel(110, 60);
    n_checks += 2;
    if (bus.alive_o !== 1'b0)   begin n_err++; $display("FAIL dead_kill_alive: got %b want 0", bus.alive_o); end
    if (bus.pixel_hit !== 1'b0) begin n_err++; $display("FAIL dead_hit: got %b want 0", bus.pixel_hit); end
    pulse_ctrl(1'b1, 1'b1);
    n_checks++;
    if (bus.alive_o !== 1'b1) begin n_err++; $display("FAIL spawn_kill_dead: got %b want 1", bus.alive_o); end
  endtask

  task automatic test_reset_midscan;
    bit eh; int ea; logic [23:0] eo;
    pulse_ctrl(1'b0, 1'b1);
    frame_pulse();
    hold_pixel(110, 60);
    model_pix(110, 60, ea, eh, eo);
    n_checks++;
    if (bus.pixel_hit !== eh) begin n_err++; $display("FAIL pre_reset_hit: got %b want %b", bus.pixel_hit, eh); end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    n_checks += 4;
    if (bus.read_address !== 19'd0) begin n_err++; $display("FAIL mid_reset_addr: got %0d want 0", bus.read_address); end
    if (bus.pixel_out !== 24'h0)    begin n_err++; $display("FAIL mid_reset_pix: got %h want 0", bus.pixel_out); end
    if (bus.pixel_hit !== 1'b0)     begin n_err++; $display("FAIL mid_reset_hit: got %b want 0", bus.pixel_hit); end
    if (bus.alive_o !== 1'b0)       begin n_err++; $display("FAIL mid_reset_alive: got %b want 0", bus.alive_o); end
    pulse_ctrl(1'b0, 1'b1);
    frame_pulse();
    hold_pixel(110, 60);
    n_checks += 2;
    if (bus.alive_o !== 1'b0)   begin n_err++; $display("FAIL post_reset_kill: got %b want 0", bus.alive_o); end
    if (bus.pixel_hit !== 1'b0) begin n_err++; $display("FAIL post_reset_hit: got %b want 0", bus.pixel_hit); end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.spawn       = 1'b0;
    bus.kill        = 1'b0;
    bus.alien_x     = 10'd0;
    bus.alien_y     = 10'd0;
    bus.DrawX       = 10'd0;
    bus.DrawY       = 10'd0;
    bus.data_Out    = 24'h0;
    for (int i = 0; i < 1600; i++)
      ram[i] = ($urandom_range(0, 7) == 0) ? TRANSP : 24'($urandom);
    ram[0]    = 24'h00FF00;
    ram[39]   = 24'hABCDEF;
    ram[41]   = TRANSP;
    ram[410]  = 24'h102030;
    ram[429]  = 24'h405060;
    ram[1560] = 24'h0A0B0C;
    ram[1599] = 24'h123456;
    model_reset();

    test_reset();
    test_spawn_hit();
    test_transparent_latch();
    test_flip();
    test_random_scan();
    test_dying();
    test_reset_midscan();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alien_sprite_reader.md
# alien_sprite_reader

Read-side pixel fetcher for the 40x40 alien sprite RAM (24-bit RGB, 1600 words, addresses 0-1599, write port used by the loader, read port owned by this block). Given the VGA scan position, it decides whether the current pixel falls inside the alien's box and issues the matching `read_address`. It then aligns the returned `data_Out` with a hit flag and the animation/death state, and presents a registered pixel plus hit indication to the colour mapper. It sits between the VGA controller, the alien game logic and `alienRAM`'s read port.

## Interface
- SPR_W, 40, sprite width/height in pixels (square)
- TRANSPARENT, 24'hFF00FF, colour key treated as "no pixel"
- FLIP_FRAMES, 16, frames between horizontal-mirror toggles (walk animation)
- DIE_FRAMES, 32, frames spent in DYING before DEAD

- Clk  in  1  system clock; one clock domain; all logic rising-edge
- Reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- alien_x  in  10  left edge of sprite box, screen pixels
- alien_y  in  10  top edge of sprite box, screen pixels
- spawn  in  1  one-cycle pulse: make alien ALIVE
- kill  in  1  one-cycle pulse: alien hit, begin DYING
- DrawX  in  10  current scan column
- DrawY  in  10  current scan row
- read_address  out  19  to RAM read port
- data_Out  in  24  from RAM read port, valid one cycle after read_address
- pixel_out  out  24  sprite colour, 0 when pixel_hit=0
- pixel_hit  out  1  sprite pixel is opaque and visible at this position
- alive_o  out  1  state == ALIVE

## Operation
- State machine: DEAD -> ALIVE on spawn; ALIVE -> DYING on kill; DYING -> DEAD after DIE_FRAMES frame_start pulses; DEAD ignores kill; ALIVE/DYING ignore spawn.
- Simultaneous spawn+kill: in DEAD, spawn wins; in ALIVE, kill wins; in DYING, both ignored.
- Entering DYING clears the die counter. A frame_start on the same edge is not counted; only frame_start pulses seen while already in DYING increment the counter. On the edge where the count reaches DIE_FRAMES, the next state is DEAD.
- Visibility: ALIVE always visible; DYING visible when die counter bit 2 = 0 (blink every 4 frames); DEAD never visible.
- Position latch: on frame_start, x_lat/y_lat <= alien_x/alien_y. Mid-frame position changes have no effect until the next frame_start.
- Flip: flip counter increments on frame_start in ALIVE. When it reaches FLIP_FRAMES-1, it wraps to 0 and flip toggles. Both are frozen in DYING/DEAD.
- In-box test, done in 11-bit unsigned arithmetic with no wrap: DrawX >= x_lat, DrawX < x_lat+SPR_W, DrawY >= y_lat, DrawY < y_lat+SPR_W. Boxes extending past column 639 or row 479 are simply clipped.
- dx = DrawX-x_lat and dy = DrawY-y_lat, each 0..39. col = flip ? SPR_W-1-dx : dx.
- Address = dy*SPR_W + col, range 0..1599, zero-extended to 19 bits. Outside the box, read_address holds 0 and the in-box flag is 0.

## Timing
- Stage 1, edge N+1: read_address, in-box flag s1 and visibility v1 registered from the DrawX/DrawY/state present in cycle N.
- Stage 2, edge N+2: RAM registers data_Out; s2/v2 registered from s1/v1.
- Stage 3, edge N+3: pixel_hit <= s2 & v2 & (data_Out != TRANSPARENT); pixel_out <= hit ? data_Out : 0.
- Total latency DrawX/DrawY -> pixel_out/pixel_hit is 3 cycles. The VGA side compensates.
- State, visibility and latched position changes propagate through the pipeline. Up to 3 in-flight pixels use the old values; no flush.
- Reset values: read_address 0, pixel_out 0, pixel_hit 0, alive_o 0, state DEAD, flip 0, all counters 0, x_lat/y_lat 0, pipeline flags 0.
- Reset asserted mid-frame: every register above takes its reset value on that edge. pixel_hit stays 0 until a spawn plus at least 3 cycles of valid scan have elapsed.

## Test plan
- Reset, spawn, frame_start with alien_x=100, alien_y=50; scan DrawX=100, DrawY=50 -> read_address 0 at N+1; RAM word 0 = 24'h00FF00 -> pixel_hit=1, pixel_out=24'h00FF00 at N+3.
- Same setup, scan DrawX=139, DrawY=89 -> read_address 1599. Scan DrawX=140 or DrawY=49 -> pixel_hit=0, pixel_out=0, read_address 0.
- Word 41 = TRANSPARENT, scan DrawX=101, DrawY=51 -> pixel_hit=0. Change alien_x to 200 mid-frame -> hits stay at x=100 until the next frame_start.
- ALIVE, 16 frame_start pulses -> flip=1. DrawX=100, DrawY=50 -> read_address 39.
- kill, then frame_start pulses: frames with counter 4-7 show pixel_hit=0, counter 0-3 show hits. After 32 pulses, state is DEAD and alive_o=0. spawn+kill in the same cycle from DEAD -> ALIVE.
- Assert Reset during DYING mid-scan -> all outputs 0 next edge, state DEAD; kill alone afterwards leaves state DEAD.
